triangle_gen: RTL and testbench

TRIANGLE_GEN -- requirements
Module: triangle_gen

---
 rtl/triangle_gen.sv | 137 +++++++++++++
 tb/tb_triangle_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_gen.sv
// triangle_gen
//   Enumerates every non-degenerate integer triangle (A<=B<=C<=N, A+B>C)
//   in lexicographic order on (A,B,C), C fastest, over a VALID/READY
//   handshake. One triple per cycle when READY is held high.
//
// Ports
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   START  : begin an enumeration (accepted only in IDLE)
//   N      : maximum side length, latched when START is accepted
//   READY  : consumer accepts the current triple
//   VALID  : A/B/C hold a valid triple
//   A,B,C  : current triple
//   BUSY   : enumeration in progress (RUN or FIN)
//   DONE   : one-cycle pulse after the last transfer
//   COUNT  : triples transferred in the current or last run
module triangle_gen #(
   parameter int unsigned W = 8
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           START,
   input  logic [W-1:0]   N,
   input  logic           READY,
   output logic           VALID,
   output logic [W-1:0]   A,
   output logic [W-1:0]   B,
   output logic [W-1:0]   C,
   output logic           BUSY,
   output logic           DONE,
   output logic [3*W-1:0] COUNT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [W-1:0]   n_q, n_nx;
   logic [W-1:0]   a_q, a_nx;
   logic [W-1:0]   b_q, b_nx;
   logic [W-1:0]   c_q, c_nx;
   logic [3*W-1:0] cnt_q, cnt_nx;

   logic           xfer;
   logic [W:0]     sum_m1;
   logic [W:0]     limit;
   logic           c_step;
   logic           b_step;
   logic           a_step;

   // Largest legal C for the current (A,B) is min(N, A+B-1); the sum is
   // kept one bit wider so A=B=2^W-1 cannot wrap.
   always_comb begin
      sum_m1 = {1'b0, a_q} + {1'b0, b_q} - (W+1)'(1);
      limit  = ({1'b0, n_q} < sum_m1) ? {1'b0, n_q} : sum_m1;
      c_step = ({1'b0, c_q} < limit);
      b_step = (b_q < n_q);
      a_step = (a_q < n_q);
   end

   assign xfer = (state == RUN) && READY;

   always_comb begin
      state_nx = state;
      n_nx     = n_q;
      a_nx     = a_q;
      b_nx     = b_q;
      c_nx     = c_q;
      cnt_nx   = cnt_q;
      case (state)
         IDLE: begin
            if (START) begin
               n_nx   = N;
               cnt_nx = '0;
               if (N == '0) begin
                  state_nx = FIN;
               end else begin
                  state_nx = RUN;
                  a_nx     = W'(1);
                  b_nx     = W'(1);
                  c_nx     = W'(1);
               end
            end
         end
         RUN: begin
            if (xfer) begin
               cnt_nx = cnt_q + (3*W)'(1);
               if (c_step) begin
                  c_nx = c_q + W'(1);
               end else if (b_step) begin
                  b_nx = b_q + W'(1);
                  c_nx = b_q + W'(1);
               end else if (a_step) begin
                  a_nx = a_q + W'(1);
                  b_nx = a_q + W'(1);
                  c_nx = a_q + W'(1);
               end else begin
                  // last triple handed over; A/B/C keep their final value
                  state_nx = FIN;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         n_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nx;
         n_q   <= n_nx;
         a_q   <= a_nx;
         b_q   <= b_nx;
         c_q   <= c_nx;
         cnt_q <= cnt_nx;
      end
   end

   assign VALID = (state == RUN);
   assign BUSY  = (state != IDLE);
   assign DONE  = (state == FIN);
   assign A     = a_q;
   assign B     = b_q;
   assign C     = c_q;
   assign COUNT = cnt_q;

endmodule

// File: tb/tb_triangle_gen.sv
// Directed bench for triangle_gen: reset, N=0, N=3 full rate, ignored
// re-START, N=4 with random READY, mid-run reset, and the N=255 corners.
module tb_triangle_gen;

   localparam int W = 8;

   logic           CLK = 1'b0;
   logic           RST_N;
   logic           START;
   logic [W-1:0]   N;
   logic           READY;
   logic           VALID;
   logic [W-1:0]   A, B, C;
   logic           BUSY;
   logic           DONE;
   logic [3*W-1:0] COUNT;

   int tests = 0;
   int fails = 0;

   int qa[$], qb[$], qc[$];
   int ea[$], eb[$], ec[$];
   int stall_err;
   int done_iter;
   logic done_valid;

   always #5 CLK = ~CLK;

   triangle_gen #(.W(W)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .N     (N),
      .READY (READY),
      .VALID (VALID),
      .A     (A),
      .B     (B),
      .C     (C),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .COUNT (COUNT)
   );

   initial begin
      #200000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference enumeration straight from the definition: all A<=B<=C<=n
   // with A+B>C, lexicographic, C fastest.
   task automatic build_model(input int n);
      ea.delete(); eb.delete(); ec.delete();
      for (int a = 1; a <= n; a++)
         for (int b = a; b <= n; b++)
            for (int c = b; c <= n; c++)
               if (a + b > c) begin
                  ea.push_back(a); eb.push_back(b); ec.push_back(c);
               end
   endtask

   task automatic start_run(input int n);
      @(negedge CLK);
      N     = W'(n);
      START = 1'b1;
   endtask

   // Drives READY, records transferred triples, counts stall violations,
   // stops at DONE, at the budget, or after abort_after transfers.
   task automatic collect(input int unsigned pct, input int budget,
                          input int restart_at, input int abort_after);
      logic pv, pr;
      logic [W-1:0] pa, pb, pc;
      pv = 1'b0; pr = 1'b0; pa = '0; pb = '0; pc = '0;
      qa.delete(); qb.delete(); qc.delete();
      stall_err  = 0;
      done_iter  = -1;
      done_valid = 1'bx;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         START = (i == restart_at);
         if (START) N = W'(9);
         if (pv && !pr && (VALID !== 1'b1 || A !== pa || B !== pb || C !== pc))
            stall_err++;
         if (abort_after > 0 && qa.size() == abort_after) break;
         if (DONE === 1'b1) begin
            done_iter  = i;
            done_valid = VALID;
            break;
         end
         READY = ($urandom_range(99) < pct);
         pv = VALID; pr = READY; pa = A; pb = B; pc = C;
         if (VALID === 1'b1 && READY) begin
            qa.push_back(int'(A)); qb.push_back(int'(B)); qc.push_back(int'(C));
         end
      end
      START = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; READY = 1'b0; N = '0;
      #12;
      tests++;
      if ({VALID, A, B, C, BUSY, DONE, COUNT} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got V=%b A=%0d B=%0d C=%0d BUSY=%b DONE=%b COUNT=%0d required all 0",
                  VALID, A, B, C, BUSY, DONE, COUNT);
      end
      @(negedge CLK); START = 1'b1; N = W'(3);
      @(negedge CLK);
      tests++;
      if (BUSY !== 1'b0 || VALID !== 1'b0) begin
         fails++;
         $display("FAIL reset_holds_idle: got BUSY=%b VALID=%b required 0 0", BUSY, VALID);
      end
      START = 1'b0;
      RST_N = 1'b1;
   endtask

   task automatic test_n0();
      start_run(0);
      collect(100, 10, -1, 0);
      tests++;
      if (done_iter !== 0 || qa.size() != 0) begin
         fails++;
         $display("FAIL n0_done: got done_iter=%0d transfers=%0d required 0 0", done_iter, qa.size());
      end
      tests++;
      if (COUNT !== '0) begin
         fails++;
         $display("FAIL n0_count: got %0d required 0", COUNT);
      end
      @(negedge CLK);
      tests++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         fails++;
         $display("FAIL n0_idle: got DONE=%b BUSY=%b required 0 0", DONE, BUSY);
      end
   endtask

   task automatic test_n3();
      int exp3 [7][3];
      exp3 = '{'{1,1,1}, '{1,2,2}, '{1,3,3}, '{2,2,2}, '{2,2,3}, '{2,3,3}, '{3,3,3}};
      start_run(3);
      collect(100, 50, -1, 0);
      tests++;
      if (qa.size() != 7) begin
         fails++;
         $display("FAIL n3_len: got %0d required 7", qa.size());
      end
      for (int i = 0; i < 7; i++) begin
         if (i < qa.size()) begin
            tests++;
            if (qa[i] != exp3[i][0] || qb[i] != exp3[i][1] || qc[i] != exp3[i][2]) begin
               fails++;
               $display("FAIL n3_triple%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                        i, qa[i], qb[i], qc[i], exp3[i][0], exp3[i][1], exp3[i][2]);
            end
         end
      end
      tests++;
      if (done_iter !== 7 || done_valid !== 1'b0) begin
         fails++;
         $display("FAIL n3_no_bubbles: got done_iter=%0d valid_at_done=%b required 7 0", done_iter, done_valid);
      end
      tests++;
      if (COUNT !== 7) begin
         fails++;
         $display("FAIL n3_count: got %0d required 7", COUNT);
      end
      @(negedge CLK);
      tests++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || COUNT !== 7) begin
         fails++;
         $display("FAIL n3_after_done: got DONE=%b BUSY=%b COUNT=%0d required 0 0 7", DONE, BUSY, COUNT);
      end
   endtask

   task automatic test_start_ignored();
      build_model(3);
      start_run(3);
      collect(100, 50, 2, 0);
      tests++;
      if (qa.size() != 7) begin
         fails++;
         $display("FAIL restart_len: got %0d required 7", qa.size());
      end
      for (int i = 0; i < qa.size() && i < ea.size(); i++) begin
         tests++;
         if (qa[i] != ea[i] || qb[i] != eb[i] || qc[i] != ec[i]) begin
            fails++;
            $display("FAIL restart_triple%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     i, qa[i], qb[i], qc[i], ea[i], eb[i], ec[i]);
         end
      end
      tests++;
      if (COUNT !== 7) begin
         fails++;
         $display("FAIL restart_count: got %0d required 7", COUNT);
      end
   endtask

   task automatic test_random_n4();
      build_model(4);
      start_run(4);
      collect(50, 400, -1, 0);
      tests++;
      if (qa.size() != 13 || done_iter < 0) begin
         fails++;
         $display("FAIL rnd_len: got %0d transfers done_iter=%0d required 13 and DONE", qa.size(), done_iter);
      end
      for (int i = 0; i < qa.size() && i < ea.size(); i++) begin
         tests++;
         if (qa[i] != ea[i] || qb[i] != eb[i] || qc[i] != ec[i]) begin
            fails++;
            $display("FAIL rnd_triple%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     i, qa[i], qb[i], qc[i], ea[i], eb[i], ec[i]);
         end
      end
      tests++;
      if (stall_err != 0) begin
         fails++;
         $display("FAIL rnd_stall_stable: got %0d violations required 0", stall_err);
      end
      tests++;
      if (COUNT !== 13) begin
         fails++;
         $display("FAIL rnd_count: got %0d required 13", COUNT);
      end
   endtask

   task automatic test_reset_mid_run();
      start_run(4);
      collect(100, 50, -1, 5);
      tests++;
      if (qa.size() != 5 || COUNT !== 5 || VALID !== 1'b1 || A !== 2 || B !== 2 || C !== 3) begin
         fails++;
         $display("FAIL abort_pre: got n=%0d COUNT=%0d V=%b (%0d,%0d,%0d) required 5 5 1 (2,2,3)",
                  qa.size(), COUNT, VALID, A, B, C);
      end
      READY = 1'b0;
      RST_N = 1'b0;
      #1;
      tests++;
      if ({VALID, A, B, C, BUSY, DONE, COUNT} !== '0) begin
         fails++;
         $display("FAIL abort_async: got V=%b A=%0d B=%0d C=%0d BUSY=%b DONE=%b COUNT=%0d required all 0",
                  VALID, A, B, C, BUSY, DONE, COUNT);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         tests++;
         if (DONE !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got DONE=%b required 0", DONE);
         end
      end
      RST_N = 1'b1;
      START = 1'b1;
      N     = W'(3);
      collect(100, 50, -1, 0);
      tests++;
      if (done_iter !== 7 || qa.size() != 7 || COUNT !== 7) begin
         fails++;
         $display("FAIL abort_restart: got done_iter=%0d n=%0d COUNT=%0d required 7 7 7",
                  done_iter, qa.size(), COUNT);
      end
   endtask

   task automatic test_n255();
      int  mism, exp_n, la, lb, lc;
      bit  tmo, got, seen1, seen128, seen127;
      mism = 0; exp_n = 0; tmo = 0; seen1 = 0; seen128 = 0; seen127 = 0;
      la = 0; lb = 0; lc = 0;
      start_run(255);
      for (int a = 1; a <= 255 && !tmo; a++)
         for (int b = a; b <= 255 && !tmo; b++)
            for (int c = b; c <= 255 && !tmo; c++)
               if (a + b > c) begin
                  exp_n++;
                  got = 0;
                  for (int k = 0; k < 8 && !got; k++) begin
                     @(negedge CLK);
                     START = 1'b0;
                     READY = 1'b1;
                     if (VALID === 1'b1) begin
                        got = 1;
                        if (A != a || B != b || C != c) mism++;
                        if (A == 1 && B == 255 && C == 255) seen1 = 1;
                        if (A == 128 && B == 128 && C == 255) seen128 = 1;
                        if (A == 127 && B == 128 && C == 255) seen127 = 1;
                        la = int'(A); lb = int'(B); lc = int'(C);
                     end
                  end
                  if (!got) tmo = 1;
               end
      tests++;
      if (tmo || mism != 0) begin
         fails++;
         $display("FAIL n255_sequence: got timeout=%0d mismatches=%0d required 0 0", tmo, mism);
      end
      tests++;
      if (!seen1 || !seen128 || seen127) begin
         fails++;
         $display("FAIL n255_corners: got seen(1,255,255)=%0d seen(128,128,255)=%0d seen(127,128,255)=%0d required 1 1 0",
                  seen1, seen128, seen127);
      end
      tests++;
      if (la != 255 || lb != 255 || lc != 255) begin
         fails++;
         $display("FAIL n255_last: got (%0d,%0d,%0d) required (255,255,255)", la, lb, lc);
      end
      @(negedge CLK);
      tests++;
      if (DONE !== 1'b1 || VALID !== 1'b0 || COUNT !== exp_n) begin
         fails++;
         $display("FAIL n255_done: got DONE=%b VALID=%b COUNT=%0d required 1 0 %0d", DONE, VALID, COUNT, exp_n);
      end
   endtask

   initial begin
      test_reset();
      test_n0();
      test_n3();
      test_start_ignored();
      test_random_n4();
      test_reset_mid_run();
      test_n255();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
